opb_stage: RTL and testbench

Parametrised operand-B path for the 5-stage pipelined CPU: the operand-B/store-data slice of the ID/EX pipeline register plus the EX-stage forwarding mux. Captures RD2, the immediate, rs2 and the B-select in ID. In EX, it drives the ALU B operand and the store data, forwarding from EX/MEM or MEM/WB when rs2 matches a pending write. Replaces the single-cycle two-way RD2/imm select.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/opb_fwd_unit.sv | 47 ++++
 rtl/opb_stage.sv | 157 +++++++++++++++
 tb/tb_opb_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined CPU datapath slices.
//   - Default datapath and register-address widths.
//   - Forwarding-source codes reported on fwd_src. The same codes are used by
//     every forwarding unit (operand B today, operand A later).
// No ports; imported with "import cpu_pkg::*;".
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RA_W_DEF  = 5;

    typedef logic [1:0] fwd_src_t;

    localparam fwd_src_t FWD_NONE  = 2'd0;
    localparam fwd_src_t FWD_EXMEM = 2'd1;
    localparam fwd_src_t FWD_MEMWB = 2'd2;
    localparam fwd_src_t FWD_WT    = 2'd3;

endpackage

// File: rtl/opb_fwd_unit.sv
// -----------------------------------------------------------------------------
// opb_fwd_unit
// Combinational priority compare that decides where a source register value
// must come from in EX. Written generically so the operand-A path can reuse it.
// Ports:
//   rs_i        source register address held in EX
//   exmem_we_i  EX/MEM stage will write a register
//   exmem_rd_i  EX/MEM destination register
//   memwb_we_i  MEM/WB stage will write a register
//   memwb_rd_i  MEM/WB destination register
//   wt_i        value was already written through while in ID
//   fwd_sel_o   chosen source (FWD_NONE/FWD_EXMEM/FWD_MEMWB/FWD_WT)
// -----------------------------------------------------------------------------
module opb_fwd_unit
    import cpu_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic            exmem_we_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic            memwb_we_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic            wt_i,
    output fwd_src_t        fwd_sel_o
);

    logic rs_nonzero;

    // Register x0 is hard-wired to zero, so a "write" to it must never be
    // forwarded even if a stage claims to write it.
    assign rs_nonzero = (rs_i != '0);

    // The younger producer (EX/MEM) wins over the older one (MEM/WB); the
    // write-through flag only matters when no in-flight producer matches.
    always_comb begin
        fwd_sel_o = FWD_NONE;
        if (exmem_we_i && (exmem_rd_i == rs_i) && rs_nonzero) begin
            fwd_sel_o = FWD_EXMEM;
        end else if (memwb_we_i && (memwb_rd_i == rs_i) && rs_nonzero) begin
            fwd_sel_o = FWD_MEMWB;
        end else if (wt_i) begin
            fwd_sel_o = FWD_WT;
        end
    end

endmodule

// File: rtl/opb_stage.sv
// -----------------------------------------------------------------------------
// opb_stage
// Operand-B / store-data slice of the ID/EX pipeline register plus the EX-stage
// forwarding mux.
// Configuration macro: OPB_PERF_CNT_EN (enables the forwarding event counter;
// when undefined fwd_cnt is tied to zero and no counter flops exist).
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   stall, flush         hold ID/EX contents / insert a bubble (flush wins)
//   id_valid             ID holds a real instruction
//   alub_sel             1 selects imm, 0 selects the register value
//   rd2, imm, rs2        ID-stage register read, immediate, source address
//   exmem_we/rd/res      EX/MEM write-back candidate
//   memwb_we/rd/res      MEM/WB write-back candidate
//   operand_b            ALU B operand in EX
//   store_data           forwarded rs2 value for stores in EX
//   ex_valid             EX holds a real instruction
//   fwd_src              0 none, 1 EX/MEM, 2 MEM/WB, 3 ID write-through
//   fwd_cnt              forwarding event counter
// -----------------------------------------------------------------------------
module opb_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA_W  = RA_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             alub_sel,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] imm,
    input  logic [RA_W-1:0]  rs2,
    input  logic             exmem_we,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_res,
    input  logic             memwb_we,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_res,
    output logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] store_data,
    output logic             ex_valid,
    output logic [1:0]       fwd_src,
    output logic [31:0]      fwd_cnt
);

    logic             valid_q, valid_d;
    logic             sel_q,   sel_d;
    logic [WIDTH-1:0] rd2_q,   rd2_d;
    logic [WIDTH-1:0] imm_q,   imm_d;
    logic [RA_W-1:0]  rs2_q,   rs2_d;
    logic             wt_q,    wt_d;

    logic             wt_hit;
    fwd_src_t         fwd_sel;
    logic [WIDTH-1:0] fwd_val;

    // The register file is written at the end of the cycle, so a MEM/WB write
    // to rs2 in the same cycle ID reads it would be missed; capture the
    // written value instead and remember that we did.
    assign wt_hit = memwb_we && (memwb_rd == rs2) && (rs2 != '0);

    // Next-state for the ID/EX slice: flush beats stall beats load.
    always_comb begin
        valid_d = valid_q;
        sel_d   = sel_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs2_d   = rs2_q;
        wt_d    = wt_q;
        if (flush) begin
            valid_d = 1'b0;
            sel_d   = 1'b0;
            rd2_d   = '0;
            imm_d   = '0;
            rs2_d   = '0;
            wt_d    = 1'b0;
        end else if (!stall) begin
            valid_d = id_valid;
            sel_d   = alub_sel;
            rd2_d   = wt_hit ? memwb_res : rd2;
            imm_d   = imm;
            rs2_d   = rs2;
            wt_d    = wt_hit;
        end
    end

    // ID/EX pipeline register for the operand-B fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs2_q   <= '0;
            wt_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs2_q   <= rs2_d;
            wt_q    <= wt_d;
        end
    end

    opb_fwd_unit #(
        .RA_W (RA_W)
    ) u_fwd (
        .rs_i       (rs2_q),
        .exmem_we_i (exmem_we),
        .exmem_rd_i (exmem_rd),
        .memwb_we_i (memwb_we),
        .memwb_rd_i (memwb_rd),
        .wt_i       (wt_q),
        .fwd_sel_o  (fwd_sel)
    );

    // Forwarded rs2 value; the write-through case already holds the right
    // value in rd2_q, so it shares the default leg.
    always_comb begin
        fwd_val = rd2_q;
        case (fwd_sel)
            FWD_EXMEM: fwd_val = exmem_res;
            FWD_MEMWB: fwd_val = memwb_res;
            default:   fwd_val = rd2_q;
        endcase
    end

    assign store_data = fwd_val;
    assign operand_b  = sel_q ? imm_q : fwd_val;
    assign ex_valid   = valid_q;
    // Report a forward only when it actually feeds the ALU of a live op.
    assign fwd_src    = (valid_q && !sel_q) ? fwd_sel : FWD_NONE;

`ifdef OPB_PERF_CNT_EN
    logic [31:0] fwd_cnt_q;

    // Counts forwarded operands of instructions that leave EX this cycle;
    // sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q <= '0;
        end else if (ex_valid && !stall && (fwd_src != FWD_NONE)
                     && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign fwd_cnt = fwd_cnt_q;
`else
    assign fwd_cnt = '0;
`endif

endmodule

// File: tb/tb_opb_stage.sv
// -----------------------------------------------------------------------------
// tb_opb_stage
// Self-checking bench for opb_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the EX-stage instruction.
// Honours OPB_PERF_CNT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_opb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, flush, idValid, alubSel;
    logic [31:0] rd2, imm;
    logic [4:0]  rs2;
    logic        exmemWe, memwbWe;
    logic [4:0]  exmemRd, memwbRd;
    logic [31:0] exmemRes, memwbRes;
    logic [31:0] operandB, storeData, fwdCnt;
    logic        exValid;
    logic [1:0]  fwdSrc;

    int checkCount = 0;
    int errorCount = 0;
    bit checkEn = 1'b0;

    // Model of the instruction sitting in EX, as seen architecturally.
    bit          mValid, mSel, mWt;
    logic [31:0] mRs2Val, mImm, mCnt;
    logic [4:0]  mRs2;

    always #5 clk = ~clk;

    opb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .id_valid   (idValid),
        .alub_sel   (alubSel),
        .rd2        (rd2),
        .imm        (imm),
        .rs2        (rs2),
        .exmem_we   (exmemWe),
        .exmem_rd   (exmemRd),
        .exmem_res  (exmemRes),
        .memwb_we   (memwbWe),
        .memwb_rd   (memwbRd),
        .memwb_res  (memwbRes),
        .operand_b  (operandB),
        .store_data (storeData),
        .ex_valid   (exValid),
        .fwd_src    (fwdSrc),
        .fwd_cnt    (fwdCnt)
    );

    // Compare one value and record the result.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Newest pending writer of the EX source register supplies its value;
    // x0 always reads as whatever was captured.
    function automatic void modelOut(output logic [31:0] opb, output logic [31:0] sd,
                                     output logic [1:0] src);
        logic [31:0] val;
        logic [1:0]  s;
        val = mRs2Val;
        s   = mWt ? 2'd3 : 2'd0;
        if (mRs2 != 5'd0) begin
            if (exmemWe && exmemRd == mRs2) begin
                val = exmemRes;
                s   = 2'd1;
            end else if (memwbWe && memwbRd == mRs2) begin
                val = memwbRes;
                s   = 2'd2;
            end
        end
        sd  = val;
        opb = mSel ? mImm : val;
        src = (mValid && !mSel) ? s : 2'd0;
    endfunction

    function automatic void modelReset();
        mValid = 0; mSel = 0; mWt = 0;
        mRs2Val = '0; mImm = '0; mRs2 = '0; mCnt = '0;
    endfunction

    // Advance the model across one rising edge using the inputs seen there.
    function automatic void modelClock();
        logic [31:0] o, sd;
        logic [1:0]  s;
        modelOut(o, sd, s);
`ifdef OPB_PERF_CNT_EN
        if (mValid && !stall && s != 2'd0 && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
`endif
        if (flush) begin
            mValid = 0; mSel = 0; mWt = 0; mRs2Val = '0; mImm = '0; mRs2 = '0;
        end else if (!stall) begin
            mValid  = idValid;
            mSel    = alubSel;
            mImm    = imm;
            mRs2    = rs2;
            mWt     = memwbWe && memwbRd == rs2 && rs2 != 5'd0;
            mRs2Val = mWt ? memwbRes : rd2;
        end
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] eo, es;
        logic [1:0]  ef;
        if (checkEn) begin
            modelOut(eo, es, ef);
            checkOutput("operand_b", operandB, eo);
            checkOutput("store_data", storeData, es);
            checkOutput("ex_valid", {31'd0, exValid}, {31'd0, mValid});
            checkOutput("fwd_src", {30'd0, fwdSrc}, {30'd0, ef});
            checkOutput("fwd_cnt", fwdCnt, mCnt);
        end
    end

    task automatic applyStimulus(input bit v, input bit sel, input logic [31:0] r,
                                 input logic [31:0] i, input logic [4:0] rs,
                                 input bit st, input bit fl);
        idValid = v; alubSel = sel; rd2 = r; imm = i; rs2 = rs; stall = st; flush = fl;
    endtask

    task automatic setForward(input bit ew, input logic [4:0] er, input logic [31:0] eres,
                              input bit mw, input logic [4:0] mr, input logic [31:0] mres);
        exmemWe = ew; exmemRd = er; exmemRes = eres;
        memwbWe = mw; memwbRd = mr; memwbRes = mres;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) modelClock();
        #1;
    endtask

    task automatic toCheckPoint();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] base;
        modelReset();
        applyStimulus(0, 0, '0, '0, '0, 0, 0);
        setForward(0, '0, '0, 0, '0, '0);
        repeat (2) tick();
        #4 rst_n = 1'b1;
        checkEn = 1'b1;

        // Reset asserted mid-cycle while fields are loaded.
        applyStimulus(1, 1, 32'h77, 32'h1234, 5'd9, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst operand_b", operandB, 32'h0);
        checkOutput("rst store_data", storeData, 32'h0);
        checkOutput("rst ex_valid", {31'd0, exValid}, 32'h0);
        checkOutput("rst fwd_src", {30'd0, fwdSrc}, 32'h0);
        checkOutput("rst fwd_cnt", fwdCnt, 32'h0);
        #3 rst_n = 1'b1;
        applyStimulus(1, 0, 32'h5, 32'h0, 5'd1, 0, 0);
        tick();
        toCheckPoint();
        checkOutput("post-rst operand_b", operandB, 32'h5);
        checkOutput("post-rst ex_valid", {31'd0, exValid}, 32'h1);

        // Immediate path ignores a matching forward but store data does not.
        applyStimulus(1, 1, 32'h9, 32'hFFFF_FFF0, 5'd3, 0, 0);
        tick();
        setForward(1, 5'd3, 32'h1234, 0, '0, '0);
        toCheckPoint();
        checkOutput("imm operand_b", operandB, 32'hFFFF_FFF0);
        checkOutput("imm store_data", storeData, 32'h1234);
        checkOutput("imm fwd_src", {30'd0, fwdSrc}, 32'h0);

        // EX/MEM beats MEM/WB; dropping EX/MEM exposes MEM/WB.
        setForward(0, '0, '0, 0, '0, '0);
        applyStimulus(1, 0, 32'h99, 32'h0, 5'd7, 0, 0);
        tick();
        setForward(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
        toCheckPoint();
        checkOutput("prio operand_b", operandB, 32'h11);
        checkOutput("prio fwd_src", {30'd0, fwdSrc}, 32'h1);
        exmemWe = 1'b0;
        #1;
        checkOutput("memwb operand_b", operandB, 32'h22);
        checkOutput("memwb fwd_src", {30'd0, fwdSrc}, 32'h2);

        // x0 is never forwarded.
        setForward(0, '0, '0, 0, '0, '0);
        applyStimulus(1, 0, 32'h55, 32'h0, 5'd0, 0, 0);
        tick();
        setForward(1, 5'd0, 32'hDEAD, 0, '0, '0);
        toCheckPoint();
        checkOutput("x0 operand_b", operandB, 32'h55);
        checkOutput("x0 fwd_src", {30'd0, fwdSrc}, 32'h0);

        // Write-through captured in ID.
        applyStimulus(1, 0, 32'h0, 32'h0, 5'd4, 0, 0);
        setForward(0, '0, '0, 1, 5'd4, 32'hAB);
        tick();
        setForward(0, '0, '0, 0, '0, '0);
        toCheckPoint();
        checkOutput("wt operand_b", operandB, 32'hAB);
        checkOutput("wt fwd_src", {30'd0, fwdSrc}, 32'h3);

        // Stall holds for three cycles while ID changes underneath.
        applyStimulus(1, 0, 32'h66, 32'h0, 5'd6, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, $urandom, $urandom, 5'(k + 10), 1, 0);
            tick();
            toCheckPoint();
            checkOutput("stall operand_b", operandB, 32'h66);
        end
        stall = 1'b1; flush = 1'b1;
        tick();
        toCheckPoint();
        checkOutput("flush ex_valid", {31'd0, exValid}, 32'h0);
        checkOutput("flush operand_b", operandB, 32'h0);

        // Counter counts only the unstalled forwarded cycle.
        base = mCnt;
        applyStimulus(1, 0, 32'h80, 32'h0, 5'd8, 0, 0);
        setForward(0, '0, '0, 0, '0, '0);
        tick();
        setForward(1, 5'd8, 32'h88, 0, '0, '0);
        stall = 1'b1;
        toCheckPoint();
        checkOutput("cnt operand_b", operandB, 32'h88);
        tick();
        tick();
        applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        tick();
        setForward(0, '0, '0, 0, '0, '0);
        tick();
        toCheckPoint();
`ifdef OPB_PERF_CNT_EN
        checkOutput("cnt delta", fwdCnt, base + 32'd1);
`else
        checkOutput("cnt tied", fwdCnt, 32'h0);
`endif

        // Randomized traffic, including occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom, $urandom, 5'($urandom_range(0, 7)),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            setForward($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                       $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                modelReset();
                #4 rst_n = 1'b1;
            end
            tick();
        end

        toCheckPoint();
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
